// File: rtl/rv_pkg.sv
// Shared definitions for the register-file write side.
// Holds the datapath width, register-address width and register count, the
// writeback request record buffered by the long-latency result FIFO, and a
// helper that turns a register address into a scoreboard bit mask.
package rv_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One pending register-file write: destination, value and a live flag.
  // A cleared valid means the write was superseded and must not commit.
  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
    logic            valid;
  } wb_req_t;

  // One-hot mask for a register. Bit 0 is always cleared because x0 is never
  // tracked as pending.
  function automatic logic [NUM_REGS-1:0] regMask(input reg_addr_t r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_ctrl_wb_fifo.sv
// Module: wb_fifo
// Buffers long-latency results waiting for the register-file write port.
// Each entry carries its own valid flag so that a younger pipeline writeback
// to the same register can squash it in place; squashed entries still drain
// in order so the consumer can retire their scoreboard bits.
// Ports:
//   clk_i      clock, all updates on posedge
//   reset_i    synchronous active-high reset, empties the FIFO
//   push_i     write pushReq_i at the tail (caller guarantees not full)
//   pushReq_i  entry to store
//   pop_i      advance the head (caller guarantees not empty)
//   inv_i      squash every entry whose rd equals invRd_i
//   invRd_i    register address to squash
//   head_o     entry at the head
//   empty_o    no entries stored
//   full_o     DEPTH entries stored
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      push_i,
  input  wb_req_t   pushReq_i,
  input  logic      pop_i,
  input  logic      inv_i,
  input  reg_addr_t invRd_i,
  output wb_req_t   head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  wb_req_t            pushEntry;

  // Pointers are exactly log2(DEPTH) bits wide, so incrementing them wraps
  // modulo DEPTH for free. Count only moves on a lone push or a lone pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // An entry arriving in the same cycle as a squash for its register is
  // older than that writeback, so it is stored already invalidated.
  always_comb begin
    pushEntry       = pushReq_i;
    pushEntry.valid = pushReq_i.valid & ~(inv_i && (pushReq_i.rd == invRd_i));
  end

  // Storage update: squash matching entries first, then the tail write; the
  // tail slot is never live while being written, so the order cannot lose a
  // squash.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[PTR_W'(i)] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (inv_i && (mem_q[PTR_W'(i)].rd == invRd_i)) begin
          mem_q[PTR_W'(i)].valid <= 1'b0;
        end
      end
      if (push_i) begin
        mem_q[wrPtr_q] <= pushEntry;
      end
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/regfile_write_ctrl.sv
// Module: regfile_write_ctrl
// Write-side controller for registerFile. Merges pipeline writeback with
// results from the long-latency unit (load/mul) onto the single register-file
// write port, buffers long-latency results that lose arbitration, keeps the
// pending-write scoreboard used by the hazard unit, and never writes x0.
// The register file samples rd_o/writedata_o/reg_write_o on negedge, so all
// three are registered here and valid one cycle after selection.
// Datapath width is rv_pkg::XLEN.
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   wb_valid_i   pipeline writeback valid (never stalled)
//   wb_rd_i      pipeline destination register
//   wb_data_i    pipeline writeback value
//   lu_valid_i   long-latency result valid
//   lu_ready_o   result accepted when lu_valid_i & lu_ready_o
//   lu_rd_i      long-latency destination register
//   lu_data_i    long-latency result value
//   iss_valid_i  long-latency op issued this cycle
//   iss_rd_i     destination of the issued op
//   rs1_i/rs2_i  decode-stage source registers
//   haz1_o/haz2_o  source register has a pending long-latency write
//   busy_o       pending-write scoreboard
//   rd_o, writedata_o, reg_write_o  register-file write port
module regfile_write_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_rd_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                lu_valid_i,
  output logic                lu_ready_o,
  input  logic [4:0]          lu_rd_i,
  input  logic [XLEN-1:0]     lu_data_i,
  input  logic                iss_valid_i,
  input  logic [4:0]          iss_rd_i,
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  output logic                haz1_o,
  output logic                haz2_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [4:0]          rd_o,
  output logic [XLEN-1:0]     writedata_o,
  output logic                reg_write_o
);

  logic                fifoEmpty;
  logic                fifoFull;
  logic                fifoPush;
  logic                luFire;
  logic                selWb;
  logic                selPop;
  logic                selBypass;
  logic                squash;
  wb_req_t             fifoHead;
  wb_req_t             luReq;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clrMask;
  logic [NUM_REGS-1:0] setMask;
  reg_addr_t           rd_q, rd_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                we_q, we_d;

  // Port arbitration. Pipeline writeback can never stall, so it always wins.
  // Otherwise the oldest buffered result drains; only when nothing is
  // buffered may a fresh long-latency result skip the FIFO entirely, which
  // keeps long-latency results in arrival order.
  always_comb begin
    luFire    = lu_valid_i & ~fifoFull;
    selWb     = wb_valid_i;
    selPop    = ~wb_valid_i & ~fifoEmpty;
    selBypass = ~wb_valid_i & fifoEmpty & luFire;
    fifoPush  = luFire & ~selBypass;
    squash    = wb_valid_i & (wb_rd_i != '0);
    luReq       = '0;
    luReq.rd    = lu_rd_i;
    luReq.data  = lu_data_i;
    luReq.valid = 1'b1;
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .push_i   (fifoPush),
    .pushReq_i(luReq),
    .pop_i    (selPop),
    .inv_i    (squash),
    .invRd_i  (wb_rd_i),
    .head_o   (fifoHead),
    .empty_o  (fifoEmpty),
    .full_o   (fifoFull)
  );

  // Next value of the write port. A selected write to x0 or a squashed entry
  // still updates rd/data but leaves the write enable low; with nothing
  // selected the enable drops and rd/data hold.
  always_comb begin
    rd_d    = rd_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    if (selWb) begin
      rd_d    = wb_rd_i;
      wdata_d = wb_data_i;
      we_d    = (wb_rd_i != '0);
    end else if (selPop) begin
      rd_d    = fifoHead.rd;
      wdata_d = fifoHead.data;
      we_d    = fifoHead.valid & (fifoHead.rd != '0);
    end else if (selBypass) begin
      rd_d    = lu_rd_i;
      wdata_d = lu_data_i;
      we_d    = (lu_rd_i != '0);
    end
  end

  // Scoreboard. A register stops being pending the moment its long-latency
  // result is selected for the port, written or squashed. A new issue to the
  // same register in that cycle is a newer producer, so the set is applied
  // after the clear. regMask keeps bit 0 permanently clear.
  always_comb begin
    clrMask = '0;
    setMask = '0;
    if (selPop) begin
      clrMask = regMask(fifoHead.rd);
    end else if (selBypass) begin
      clrMask = regMask(lu_rd_i);
    end
    if (iss_valid_i) begin
      setMask = regMask(iss_rd_i);
    end
    busy_d = (busy_q & ~clrMask) | setMask;
  end

  // State registers for the write port and the scoreboard.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  // Hazard lookups read the registered scoreboard; an issue in this same
  // cycle is not forwarded.
  assign haz1_o      = busy_q[rs1_i] & (rs1_i != '0);
  assign haz2_o      = busy_q[rs2_i] & (rs2_i != '0);
  assign busy_o      = busy_q;
  assign lu_ready_o  = ~fifoFull;
  assign rd_o        = rd_q;
  assign writedata_o = wdata_q;
  assign reg_write_o = we_q;

endmodule
